// File: rtl/pipe_spine.sv
// Elastic pipeline backbone of STAGES generic WIDTH-bit payload stages with per-stage stall/flush.
// Latency: an item accepted at edge t sits in the last stage after edge t+STAGES-1; 1 item/cycle unstalled.
// Backpressure: elastic mode ripples accept from out_ready through each stage (bubbles collapse); rigid mode holds the whole pipe.
module pipe_spine #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter int COLLAPSE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic [STAGES-1:0]             stall_req,
    input  logic [STAGES-1:0]             flush,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*WIDTH-1:0]       stage_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [STAGES-1:0] accept;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] inc_vld;
    logic [WIDTH-1:0]  inc_dat [STAGES];
    logic              adv;

    // Walk from the output back to the input so each stage sees the accept of the stage ahead.
    always_comb begin
        logic down_ok;
        logic acc_k;
        adv     = ~|stall_req & (~vld_q[STAGES-1] | out_ready);
        accept  = '0;
        move    = '0;
        down_ok = out_ready;
        acc_k   = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (COLLAPSE != 0) begin
                move[k] = vld_q[k] & ~stall_req[k] & down_ok;
                acc_k   = ~vld_q[k] | move[k];
            end else begin
                move[k] = adv & vld_q[k];
                acc_k   = adv;
            end
            accept[k] = acc_k;
            down_ok   = acc_k;
        end
    end

    always_comb begin
        inc_vld[0] = in_valid;
        inc_dat[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            inc_vld[k] = move[k-1];
            inc_dat[k] = dat_q[k-1];
        end
    end

    // Flush beats stall beats load; payload only moves when a valid item arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k]) begin
                    vld_q[k] <= 1'b0;
                end else if (accept[k]) begin
                    vld_q[k] <= inc_vld[k];
                end
                if (accept[k] && inc_vld[k] && !flush[k]) begin
                    dat_q[k] <= inc_dat[k];
                end
            end
        end
    end

    assign in_ready    = accept[0];
    assign out_valid   = (COLLAPSE != 0) ? (vld_q[STAGES-1] & ~stall_req[STAGES-1])
                                         : (vld_q[STAGES-1] & ~|stall_req);
    assign out_data    = dat_q[STAGES-1];
    assign stage_valid = vld_q;

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt        = '0;
        stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_data[k*WIDTH +: WIDTH] = dat_q[k];
            cnt = cnt + OCC_W'(vld_q[k]);
        end
        occupancy = cnt;
    end
endmodule

// File: tb/tb_pipe_spine.sv
// Scoreboard bench: one elastic and one rigid pipe_spine (STAGES=4, WIDTH=32) driven with directed vectors.
// Drivers push expected payloads; negedge monitors pop and compare on every output handshake.
module tb_pipe_spine;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    logic [W-1:0]   e_in_data, e_out_data;
    logic [S-1:0]   e_stall, e_flush, e_sv;
    logic [S*W-1:0] e_sd;
    logic [2:0]     e_occ;

    logic           r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [W-1:0]   r_in_data, r_out_data;
    logic [S-1:0]   r_stall, r_flush, r_sv;
    logic [S*W-1:0] r_sd;
    logic [2:0]     r_occ;

    pipe_spine #(.WIDTH(W), .STAGES(S), .COLLAPSE(1)) u_el (
        .clk(clk), .rst_n(rst_n),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
        .stall_req(e_stall), .flush(e_flush),
        .stage_valid(e_sv), .stage_data(e_sd), .occupancy(e_occ)
    );

    pipe_spine #(.WIDTH(W), .STAGES(S), .COLLAPSE(0)) u_rg (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .stall_req(r_stall), .flush(r_flush),
        .stage_valid(r_sv), .stage_data(r_sd), .occupancy(r_occ)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] eq[$];
    logic [31:0] rq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && e_out_valid && e_out_ready) begin
            n_cmp++;
            if (eq.size() == 0) begin
                n_bad++;
                $display("FAIL el_out: unexpected item %0h, expected none", e_out_data);
            end else begin
                logic [31:0] x;
                x = eq.pop_front();
                if (e_out_data !== x) begin
                    n_bad++;
                    $display("FAIL el_out: got %0h, expected %0h", e_out_data, x);
                end
            end
        end
        if (rst_n && r_out_valid && r_out_ready) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rg_out: unexpected item %0h, expected none", r_out_data);
            end else begin
                logic [31:0] x;
                x = rq.pop_front();
                if (r_out_data !== x) begin
                    n_bad++;
                    $display("FAIL rg_out: got %0h, expected %0h", r_out_data, x);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int guard;
        e_in_valid = 0; e_in_data = 0; e_out_ready = 1; e_stall = 0; e_flush = 0;
        r_in_valid = 0; r_in_data = 0; r_out_ready = 1; r_stall = 0; r_flush = 0;

        // Reset state
        #12;
        chk("rst_el_out_valid", e_out_valid, 0);
        chk("rst_el_occ", e_occ, 0);
        chk("rst_el_in_ready", e_in_ready, 1);
        chk("rst_el_stage_valid", e_sv, 0);
        chk("rst_rg_in_ready", r_in_ready, 1);
        chk("rst_rg_out_valid", r_out_valid, 0);
        cyc();
        rst_n = 1;

        // Back-to-back stream 1..8
        for (int i = 1; i <= 8; i++) begin
            e_in_valid = 1; e_in_data = i; eq.push_back(i);
            #1;
            chk("t1_in_ready", e_in_ready, 1);
            cyc();
            chk("t1_out_valid", e_out_valid, (i >= 4) ? 1 : 0);
            if (i >= 4) chk("t1_out_data", e_out_data, i - 3);
        end
        e_in_valid = 0;
        repeat (4) cyc();
        chk("t1_drained_occ", e_occ, 0);

        // Backpressure: 6 cycles of out_ready=0 with continuous in_valid
        e_out_ready = 0;
        d = 20;
        for (int c = 0; c < 6; c++) begin
            e_in_valid = 1; e_in_data = d;
            #1;
            chk("t2_in_ready", e_in_ready, (c < 4) ? 1 : 0);
            if (c < 4) begin
                eq.push_back(d);
                d++;
            end
            cyc();
        end
        chk("t2_occ_full", e_occ, 4);
        chk("t2_in_ready_full", e_in_ready, 0);
        e_out_ready = 1;
        guard = 0;
        while (d < 28 && guard < 50) begin
            e_in_data = d;
            #1;
            if (e_in_ready) begin
                eq.push_back(d);
                d++;
            end
            cyc();
            guard++;
        end
        chk("t2_all_sent", d, 28);
        e_in_valid = 0;
        repeat (6) cyc();
        chk("t2_drained_occ", e_occ, 0);

        // Collapse vs rigid: A, two idle cycles, B, with out_ready=0
        e_out_ready = 0; r_out_ready = 0;
        e_in_valid = 1; e_in_data = 32'hA; eq.push_back(32'hA);
        r_in_valid = 1; r_in_data = 32'hA; rq.push_back(32'hA);
        cyc();
        e_in_valid = 0; r_in_valid = 0;
        cyc();
        cyc();
        e_in_valid = 1; e_in_data = 32'hB; eq.push_back(32'hB);
        r_in_valid = 1; r_in_data = 32'hB; rq.push_back(32'hB);
        cyc();
        e_in_valid = 0; r_in_valid = 0;
        #1;
        chk("t3_rg_in_ready_a_last", r_in_ready, 0);
        cyc();
        cyc();
        chk("t3_el_stage_valid", e_sv, 4'b1100);
        chk("t3_el_s3", e_sd[3*W +: W], 32'hA);
        chk("t3_el_s2", e_sd[2*W +: W], 32'hB);
        chk("t3_el_occ", e_occ, 2);
        chk("t3_el_in_ready", e_in_ready, 1);
        chk("t3_rg_stage_valid", r_sv, 4'b1001);
        chk("t3_rg_s0", r_sd[0 +: W], 32'hB);
        chk("t3_rg_occ", r_occ, 2);
        chk("t3_rg_in_ready", r_in_ready, 0);
        e_out_ready = 1; r_out_ready = 1;
        repeat (6) cyc();
        chk("t3_el_drained", e_occ, 0);
        chk("t3_rg_drained", r_occ, 0);

        // Elastic stall of stage 1 for 2 cycles mid-stream
        for (int i = 40; i < 44; i++) begin
            e_in_valid = 1; e_in_data = i; eq.push_back(i);
            cyc();
        end
        e_in_data = 44; e_stall = 4'b0010;
        #1;
        chk("t4_stall_in_ready0", e_in_ready, 0);
        chk("t4_stall_out_valid0", e_out_valid, 1);
        cyc();
        chk("t4_stall_in_ready1", e_in_ready, 0);
        chk("t4_stall_out_data1", e_out_data, 41);
        cyc();
        e_stall = 0;
        #1;
        chk("t4_bubbles_sv", e_sv, 4'b0011);
        chk("t4_s1_held", e_sd[1*W +: W], 42);
        chk("t4_gap0", e_out_valid, 0);
        eq.push_back(44);
        cyc();
        chk("t4_gap1", e_out_valid, 0);
        e_in_data = 45; eq.push_back(45);
        cyc();
        chk("t4_resume_valid", e_out_valid, 1);
        chk("t4_resume_data", e_out_data, 42);
        for (int i = 46; i < 48; i++) begin
            e_in_data = i; eq.push_back(i);
            cyc();
        end
        e_in_valid = 0;
        repeat (6) cyc();
        chk("t4_drained", e_occ, 0);

        // Rigid stall: whole pipe holds, no output
        for (int i = 50; i < 54; i++) begin
            r_in_valid = 1; r_in_data = i; rq.push_back(i);
            cyc();
        end
        r_in_data = 54; r_stall = 4'b0010;
        #1;
        chk("t4r_out_valid", r_out_valid, 0);
        chk("t4r_in_ready", r_in_ready, 0);
        cyc();
        chk("t4r_sv_hold", r_sv, 4'b1111);
        chk("t4r_s0_hold", r_sd[0 +: W], 53);
        cyc();
        chk("t4r_s3_hold", r_sd[3*W +: W], 50);
        r_stall = 0; rq.push_back(54);
        cyc();
        r_in_data = 55; rq.push_back(55);
        cyc();
        r_in_valid = 0;
        repeat (6) cyc();
        chk("t4r_drained", r_occ, 0);

        // Flush stages 0 and 1 of a full pipe holding 13..10
        e_out_ready = 0;
        for (int i = 10; i < 14; i++) begin
            e_in_valid = 1; e_in_data = i;
            if (i < 12) eq.push_back(i);
            cyc();
        end
        e_in_valid = 0;
        chk("t5_full_occ", e_occ, 4);
        e_flush = 4'b0011;
        cyc();
        e_flush = 0;
        chk("t5_flush_sv", e_sv, 4'b1100);
        chk("t5_flush_occ", e_occ, 2);
        chk("t5_s3_kept", e_sd[3*W +: W], 10);
        e_out_ready = 1;
        repeat (4) cyc();
        chk("t5_drained", e_occ, 0);

        // Flush and stall on the same stage
        e_out_ready = 0;
        e_in_valid = 1; e_in_data = 60;
        cyc();
        e_in_valid = 0;
        cyc();
        e_stall = 4'b0010; e_flush = 4'b0010;
        cyc();
        e_stall = 0; e_flush = 0;
        chk("t5_flush_over_stall", e_sv, 0);

        // flush[0] coinciding with an input transfer drops the item
        e_out_ready = 1;
        e_in_valid = 1; e_in_data = 70; e_flush = 4'b0001;
        #1;
        chk("t5_in_ready_with_flush", e_in_ready, 1);
        cyc();
        e_flush = 0; e_in_valid = 0;
        chk("t5_dropped_sv", e_sv, 0);
        e_in_valid = 1; e_in_data = 71; eq.push_back(71);
        cyc();
        e_in_valid = 0;
        repeat (5) cyc();
        chk("t5_after_drop_occ", e_occ, 0);

        // Async reset mid-cycle with 3 items in flight
        e_out_ready = 0;
        for (int i = 80; i < 83; i++) begin
            e_in_valid = 1; e_in_data = i;
            cyc();
        end
        e_in_valid = 0;
        chk("t6_inflight_occ", e_occ, 3);
        #2;
        rst_n = 0;
        #1;
        chk("t6_rst_sv", e_sv, 0);
        chk("t6_rst_out_valid", e_out_valid, 0);
        chk("t6_rst_occ", e_occ, 0);
        chk("t6_rst_in_ready", e_in_ready, 1);
        cyc();
        rst_n = 1;
        e_out_ready = 1;
        e_in_valid = 1; e_in_data = 90; eq.push_back(90);
        cyc();
        e_in_valid = 0;
        cyc();
        cyc();
        chk("t6_latency_not_yet", e_out_valid, 0);
        cyc();
        chk("t6_latency_valid", e_out_valid, 1);
        chk("t6_latency_data", e_out_data, 90);
        repeat (4) cyc();

        chk("el_queue_empty", eq.size(), 0);
        chk("rg_queue_empty", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
